// File: rtl/bus_pack_pkg.sv
// -----------------------------------------------------------------------------
// bus_pack_pkg
// Shared flow-control helpers for the lane packer family.
//   idx_width(n) : bit width of a counter that holds 0..n-1. For n=1 it
//                  returns 1, because a zero-width vector is not legal.
// -----------------------------------------------------------------------------
package bus_pack_pkg;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bus_pack_out_reg.sv
// -----------------------------------------------------------------------------
// bus_pack_out_reg
// One-entry valid/ready holding register that carries a data word and a
// sync flag. While the entry is valid and not accepted, it holds stable.
//
// Ports
//   clk, rst_n          clock and asynchronous active-low reset
//   load                write load_data/load_sync this edge (only when slot_free)
//   load_data[DW-1:0]   word to present downstream
//   load_sync           sync flag that travels with the word
//   slot_free           entry is empty or is draining this cycle
//   dout[DW-1:0]        held word
//   dout_valid          dout qualifies
//   dout_sync           sync flag of the held word
//   dout_ready          downstream accepts dout
// -----------------------------------------------------------------------------
module bus_pack_out_reg
  import bus_pack_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic          load_sync,
  output logic          slot_free,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          dout_sync,
  input  logic          dout_ready
);

  logic [DW-1:0] data_q, data_d;
  logic          sync_q, sync_d;
  logic          valid_q, valid_d;

  // A word that leaves on this edge frees the slot for a word arriving on
  // the same edge, so back-to-back output words need no bubble.
  assign slot_free = !valid_q || dout_ready;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    data_d  = data_q;
    sync_d  = sync_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = load_data;
      sync_d  = load_sync;
      valid_d = 1'b1;
    end else if (dout_ready) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      sync_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      sync_q  <= sync_d;
      valid_q <= valid_d;
    end
  end

  assign dout       = data_q;
  assign dout_sync  = sync_q;
  assign dout_valid = valid_q;

endmodule

// File: rtl/bus_pack.sv
// -----------------------------------------------------------------------------
// bus_pack
// Serial-to-parallel lane packer. It accepts one WIDTH-bit lane per handshake
// and assembles NOUT lanes into one NOUT*WIDTH-bit word. Lane i is placed in
// bits [i*WIDTH +: WIDTH]. When a beat arrives with din_sync set, the packer
// realigns to lane 0. Any partial word is then discarded, and drop pulses
// for one cycle.
//
// Ports
//   clk, rst_n            clock and asynchronous active-low reset
//   din[WIDTH-1:0]        input lane
//   din_valid, din_ready  input handshake (din_ready depends on state only)
//   din_sync              on an accepted beat, forces that beat to lane 0
//   dout[NOUT*WIDTH-1:0]  packed word, lane 0 in the LSBs
//   dout_valid, dout_ready output handshake
//   dout_sync             lane 0 of the packed word carried din_sync
//   drop                  one-cycle pulse when a partial word was discarded
// -----------------------------------------------------------------------------
module bus_pack
  import bus_pack_pkg::*;
#(
  parameter int NOUT  = 4,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      din,
  input  logic                  din_valid,
  input  logic                  din_sync,
  output logic                  din_ready,
  output logic [NOUT*WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  dout_sync,
  input  logic                  dout_ready,
  output logic                  drop
);

  localparam int IDX_W = idx_width(NOUT);
  localparam int DW    = NOUT * WIDTH;

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DW-1:0]    asm_q, asm_d;
  logic             asm_sync_q, asm_sync_d;
  logic             asm_full_q, asm_full_d;
  logic             drop_q, drop_d;

  logic             beat;
  logic [IDX_W-1:0] lane;
  logic [DW-1:0]    word;
  logic             word_sync;
  logic             last;
  logic             slot_free;
  logic             load;
  logic [DW-1:0]    load_data;
  logic             load_sync;

  // A buffered complete word is the only thing that stalls the input side.
  assign din_ready = !asm_full_q;
  assign beat      = din_valid && din_ready;

  always_comb begin
    // A sync beat restarts the word at lane 0 and clears the old lanes.
    lane = din_sync ? '0 : idx_q;
    word = din_sync ? '0 : asm_q;
    for (int i = 0; i < NOUT; i++) begin
      if (lane == IDX_W'(i)) word[i*WIDTH +: WIDTH] = din;
    end
    // The sync flag belongs to lane 0, so a word that starts without sync
    // must not inherit the flag from the previous word.
    word_sync = din_sync || ((idx_q != '0) && asm_sync_q);
    last      = (lane == IDX_W'(NOUT - 1));

    idx_d      = idx_q;
    asm_d      = asm_q;
    asm_sync_d = asm_sync_q;
    asm_full_d = asm_full_q;
    drop_d     = 1'b0;
    load       = 1'b0;
    load_data  = asm_q;
    load_sync  = asm_sync_q;

    if (asm_full_q) begin
      // While a word is buffered there are no beats, so only drain it.
      if (slot_free) begin
        load       = 1'b1;
        asm_full_d = 1'b0;
      end
    end else if (beat) begin
      drop_d     = din_sync && (idx_q != '0);
      asm_d      = word;
      asm_sync_d = word_sync;
      idx_d      = last ? '0 : lane + 1'b1;
      if (last) begin
        if (slot_free) begin
          load      = 1'b1;
          load_data = word;
          load_sync = word_sync;
        end else begin
          asm_full_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      // NOTE: the wide assembly register is reset as well, so no lane ever starts undefined.
      asm_q      <= '0;
      asm_sync_q <= 1'b0;
      asm_full_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      asm_q      <= asm_d;
      asm_sync_q <= asm_sync_d;
      asm_full_q <= asm_full_d;
      drop_q     <= drop_d;
    end
  end

  assign drop = drop_q;

  bus_pack_out_reg #(.DW(DW)) u_out_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_data  (load_data),
    .load_sync  (load_sync),
    .slot_free  (slot_free),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_sync  (dout_sync),
    .dout_ready (dout_ready)
  );

endmodule

// File: tb/tb_bus_pack.sv
// -----------------------------------------------------------------------------
// tb_bus_pack
// Self-checking bench for bus_pack with NOUT=4 and WIDTH=8.
// A reference model collects accepted beats into a list of lanes and queues
// each complete word. A separate monitor pops one queued word for every
// accepted output word and compares it with dout.
// -----------------------------------------------------------------------------
module tb_bus_pack;

  localparam int NOUT  = 4;
  localparam int WIDTH = 8;
  localparam int DW    = NOUT * WIDTH;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_sync;
  logic             din_ready;
  logic [DW-1:0]    dout;
  logic             dout_valid;
  logic             dout_sync;
  logic             dout_ready;
  logic             drop;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int stalls = 0;
  int drop_exp  = 0;
  int drop_seen = 0;
  int words_seen = 0;

  logic [DW:0]      exp_q[$];   // {sync, word}
  logic [WIDTH-1:0] part[$];
  logic             part_sync = 1'b0;
  int               word_cyc[$];

  bus_pack #(.NOUT(NOUT), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .din_sync   (din_sync),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_sync  (dout_sync),
    .dout_ready (dout_ready),
    .drop       (drop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model. A beat is counted when it is handshaken before the next
  // rising edge. A sync beat starts a fresh word, and if lanes were already
  // collected they are lost and one drop pulse is expected.
  always @(negedge clk) begin
    if (!rst_n) begin
      part.delete();
      exp_q.delete();
    end else if (din_valid && din_ready) begin
      if (din_sync) begin
        if (part.size() != 0) drop_exp++;
        part.delete();
        part_sync = 1'b1;
      end else if (part.size() == 0) begin
        part_sync = 1'b0;
      end
      part.push_back(din);
      if (part.size() == NOUT) begin
        logic [DW-1:0] w;
        w = '0;
        for (int i = 0; i < NOUT; i++) w[i*WIDTH +: WIDTH] = part[i];
        exp_q.push_back({part_sync, w});
        part.delete();
      end
    end
  end

  // Output monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (drop) drop_seen++;
      if (dout_valid && dout_ready) begin
        words_seen++;
        word_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_word: got dout=%0h with no word expected", dout);
        end else begin
          logic [DW:0] e;
          e = exp_q.pop_front();
          check("sb_dout", 64'(dout), 64'(e[DW-1:0]));
          check("sb_dout_sync", 64'(dout_sync), 64'(e[DW]));
        end
      end
    end
  end

  task automatic send(input logic [WIDTH-1:0] d, input logic s);
    int n;
    din = d;
    din_sync = s;
    din_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!din_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!din_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: din_ready stayed 0 for %0d cycles", n);
    end
    if (n != 0) stalls++;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    din_sync = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    logic [DW-1:0] w1;
    logic [WIDTH-1:0] b;

    rst_n = 1'b0;
    din = '0;
    din_valid = 1'b0;
    din_sync = 1'b0;
    dout_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_dout_valid", 64'(dout_valid), 0);
    check("rst_dout", 64'(dout), 0);
    check("rst_dout_sync", 64'(dout_sync), 0);
    check("rst_drop", 64'(drop), 0);
    check("rst_din_ready", 64'(din_ready), 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Four back-to-back beats produce one word in the cycle after the fourth beat.
    dout_ready = 1'b1;
    stalls = 0;
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    @(negedge clk);
    check("t1_latency_valid", 64'(dout_valid), 1);
    check("t1_dout", 64'(dout), 64'h44332211);
    @(negedge clk);
    check("t1_valid_one_cycle", 64'(dout_valid), 0);
    check("t1_no_stalls", 64'(stalls), 0);
    @(posedge clk);
    #1;

    // Twelve continuous beats produce three words, one every four cycles.
    word_cyc.delete();
    for (int i = 1; i <= 12; i++) send(8'(i), 1'b0);
    idle(3);
    check("t2_word_count", 64'(word_cyc.size()), 3);
    if (word_cyc.size() == 3) begin
      check("t2_spacing_a", 64'(word_cyc[1] - word_cyc[0]), 4);
      check("t2_spacing_b", 64'(word_cyc[2] - word_cyc[1]), 4);
    end
    check("t2_no_stalls", 64'(stalls), 0);

    // Backpressure: one word is held on dout and a second waits in assembly.
    dout_ready = 1'b0;
    w1 = '0;
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      if (i < NOUT) w1[i*WIDTH +: WIDTH] = b;
      send(b, 1'b0);
    end
    @(negedge clk);
    check("t3_din_ready_low", 64'(din_ready), 0);
    check("t3_held_valid", 64'(dout_valid), 1);
    check("t3_held_word", 64'(dout), 64'(w1));
    @(posedge clk);
    #1 dout_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t3_din_ready_back", 64'(din_ready), 1);
    idle(3);

    // Sync realignment in the middle of a word discards the partial lanes.
    d0 = drop_seen;
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b0);
    send(8'hB0, 1'b1);
    send(8'hB1, 1'b0);
    send(8'hB2, 1'b0);
    send(8'hB3, 1'b0);
    @(negedge clk);
    check("t4_dout", 64'(dout), 64'hB3B2B1B0);
    check("t4_dout_sync", 64'(dout_sync), 1);
    idle(2);
    check("t4_one_drop", 64'(drop_seen - d0), 1);

    // Sync at lane 0 causes no drop, and only that word carries the sync flag.
    d0 = drop_seen;
    send(8'hC0, 1'b1);
    for (int i = 1; i < 8; i++) send(8'hC0 + 8'(i), 1'b0);
    idle(3);
    check("t5_no_drop", 64'(drop_seen - d0), 0);

    // Reset asserted in the middle of a word clears the outputs asynchronously.
    send(8'h91, 1'b0);
    send(8'h92, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    check("t6_rst_dout", 64'(dout), 0);
    check("t6_rst_valid", 64'(dout_valid), 0);
    check("t6_rst_drop", 64'(drop), 0);
    d0 = drop_seen;
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(8'h51, 1'b0);
    send(8'h52, 1'b0);
    send(8'h53, 1'b0);
    send(8'h54, 1'b0);
    @(negedge clk);
    check("t6_clean_word", 64'(dout), 64'h54535251);
    idle(2);
    check("t6_no_drop", 64'(drop_seen - d0), 0);

    // Random traffic with random backpressure and occasional sync beats.
    for (int i = 0; i < 3000; i++) begin
      din_valid  = ($urandom % 10) < 7;
      din        = 8'($urandom);
      din_sync   = ($urandom % 8) == 0;
      dout_ready = ($urandom % 10) < 6;
      @(posedge clk);
      #1;
    end
    din_valid = 1'b0;
    din_sync = 1'b0;
    dout_ready = 1'b1;
    idle(20);
    check("rand_queue_drained", 64'(exp_q.size()), 0);
    check("rand_drop_count", 64'(drop_seen), 64'(drop_exp));
    check("rand_words_flowed", 64'(words_seen > 300), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
